// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Access sequencing: grant in IDLE, strobe in ISSUE, wait for the memory in WAIT
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Which requester owns the access currently in flight
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Timeout counter for the arbiter's WAIT state. Cleared while the access is
// being issued, counts every WAIT cycle without mem_rdy, and flags expiry on
// the cycle whose count reaches TIMEOUT.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, otherwise step while counting
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count taken this cycle would reach TIMEOUT
    assign expire_o = count_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between instruction
// fetch and the load/store path. Data requests win over fetches, grants are
// never preempted, and halt only blocks new fetch grants.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access that sees
// no mem_rdy within TIMEOUT WAIT cycles (returns zero data and pulses mem_err).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_d,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              mem_err
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic in_wait;
    logic abort;
    logic finish;

    assign in_wait = (state_q == WAIT);

`ifdef MEM_ARB_TIMEOUT_EN
    logic timer_clear;
    logic timer_count;
    logic timer_expire;

    assign timer_clear = (state_q == ISSUE);
    assign timer_count = in_wait && !mem_rdy;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timer_clear),
        .count_i  (timer_count),
        .expire_o (timer_expire)
    );

    // A real mem_rdy always beats expiry because counting stops when it arrives
    assign abort = in_wait && timer_expire;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign abort          = 1'b0;
`endif

    // The access in flight ends this cycle, either by mem_rdy or by abort
    assign finish = in_wait && (mem_rdy || abort);

    // Next-state: pick a requester in IDLE (data first), then strobe and wait
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = ISSUE;
                end else if (if_req && !hlt) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (finish) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, owner and latched access registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The strobe is decoded from state so reset removes it immediately
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_err   = abort;

    assign if_valid = finish && (owner_q == OWN_IF);
    assign d_valid  = finish && (owner_q == OWN_D);
    assign stall_if = if_req && !if_valid;
    assign stall_d  = d_req && !d_valid;

    assign if_rdata = (abort && (owner_q == OWN_IF)) ? '0 : mem_rdata;
    assign d_rdata  = (abort && (owner_q == OWN_D))  ? '0 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle by a transaction-level model.
module tb_mem_arbiter;

    localparam int TB_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hlt = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        stall_if;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        stall_d;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic        mem_err;

    mem_arbiter #(
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hlt       (hlt),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .stall_if  (stall_if),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .stall_d   (stall_d),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        checkOutput(name, {15'd0, actual}, {15'd0, expected});
    endtask

    // Memory responder settings
    int          memCountdown = 0;
    int          memLatency = 0;
    bit          memSilent = 1'b0;
    bit          memFixed = 1'b0;
    logic [15:0] memData = '0;

    // Requester view of last cycle's completions
    logic lastIfValid = 1'b0;
    logic lastDValid = 1'b0;
    always @(negedge clk) begin
        lastIfValid = if_valid;
        lastDValid  = d_valid;
    end

    // Advance one cycle and let the memory model react to the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdy   = 1'b0;
        mem_rdata = 16'($urandom);
        if (rst) begin
            memCountdown = 0;
        end else if (mem_en) begin
            if (!memSilent)
                memCountdown = (memLatency == 0) ? int'($urandom_range(1, 4)) : memLatency;
        end else if (memCountdown > 0) begin
            memCountdown--;
            if (memCountdown == 0) begin
                mem_rdy   = 1'b1;
                mem_rdata = memFixed ? memData : 16'($urandom);
            end
        end
    endtask

    // Random requesters: hold a request until served, then maybe issue another
    task automatic applyStimulus();
        if (lastIfValid || !if_req) begin
            if (lastIfValid || ($urandom_range(0, 2) == 0)) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = 16'($urandom);
            end
        end
        if (lastDValid || !d_req) begin
            if (lastDValid || ($urandom_range(0, 2) == 0)) begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
        end
        if ($urandom_range(0, 15) == 0) hlt = !hlt;
    endtask

    // Transaction-level model: an access is granted on an idle cycle, strobes
    // one cycle later and completes on the first mem_rdy after that
    bit          mBusy = 1'b0;
    bit          mOwnerD = 1'b0;
    bit          mWe = 1'b0;
    logic [15:0] mAddr = '0;
    logic [15:0] mWdata = '0;
    int          mPhase = 0;

    always @(negedge clk) begin : compare
        logic expEn, done, abortNow, expIfV, expDV;
        if (rst) begin
            checkFlag("reset mem_en", mem_en, 1'b0);
            checkFlag("reset mem_we", mem_we, 1'b0);
            checkOutput("reset mem_addr", mem_addr, 16'h0000);
            checkOutput("reset mem_wdata", mem_wdata, 16'h0000);
            checkFlag("reset mem_err", mem_err, 1'b0);
            checkFlag("reset if_valid", if_valid, 1'b0);
            checkFlag("reset d_valid", d_valid, 1'b0);
            mBusy  = 1'b0;
            mPhase = 0;
        end else begin
            expEn    = mBusy && (mPhase == 0);
            done     = mBusy && (mPhase >= 1) && mem_rdy;
            abortNow = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            abortNow = mBusy && (mPhase == TB_TIMEOUT) && !mem_rdy;
`endif
            expIfV = (done || abortNow) && !mOwnerD;
            expDV  = (done || abortNow) && mOwnerD;
            checkFlag("mem_en", mem_en, expEn);
            checkFlag("if_valid", if_valid, expIfV);
            checkFlag("d_valid", d_valid, expDV);
            checkFlag("stall_if", stall_if, if_req && !expIfV);
            checkFlag("stall_d", stall_d, d_req && !expDV);
            checkFlag("mem_err", mem_err, abortNow);
            if (expIfV) checkOutput("if_rdata", if_rdata, abortNow ? 16'h0000 : mem_rdata);
            if (expDV && (!mWe || abortNow)) checkOutput("d_rdata", d_rdata, abortNow ? 16'h0000 : mem_rdata);
            if (expEn) begin
                checkOutput("mem_addr", mem_addr, mAddr);
                checkFlag("mem_we", mem_we, mWe);
                if (mWe) checkOutput("mem_wdata", mem_wdata, mWdata);
            end
            if (mBusy) begin
                if (done || abortNow) mBusy = 1'b0;
                else mPhase++;
            end else if (d_req) begin
                mBusy = 1'b1; mPhase = 0; mOwnerD = 1'b1;
                mWe = d_we; mAddr = d_addr; mWdata = d_wdata;
            end else if (if_req && !hlt) begin
                mBusy = 1'b1; mPhase = 0; mOwnerD = 1'b0;
                mWe = 1'b0; mAddr = if_addr;
            end
        end
    end

    // Absolute bound on the run
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] firstAddr, secondAddr;
        bit          dDone, ifDone, ifAfterD, resumed;
        int          grants, stallBad, enCount, fetchGrants, dGrants, seenCycle;

        repeat (2) @(negedge clk);
        checkOutput("pin reset mem_addr", mem_addr, 16'h0000);
        checkFlag("pin reset mem_en", mem_en, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Fetch with a 2-cycle memory
        $display("[TB] fetch");
        memLatency = 2; memFixed = 1'b1; memData = 16'hB123;
        if_req = 1'b1; if_addr = 16'h0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkFlag("fetch mem_en c1", mem_en, 1'b1);
                checkOutput("fetch mem_addr", mem_addr, 16'h0010);
                checkFlag("fetch mem_we", mem_we, 1'b0);
            end else begin
                checkFlag("fetch mem_en other", mem_en, 1'b0);
            end
            checkFlag("fetch if_valid", if_valid, c == 3);
            checkFlag("fetch stall_if", stall_if, c < 3);
            if (c == 3) checkOutput("fetch if_rdata", if_rdata, 16'hB123);
            tick();
        end
        if_req = 1'b0;
        memFixed = 1'b0;

        // Contention: data first, fetch only after d_valid
        $display("[TB] contention");
        memLatency = 1;
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        grants = 0; stallBad = 0; dDone = 0; ifDone = 0; ifAfterD = 0;
        firstAddr = '0; secondAddr = '0;
        for (int c = 0; c < 30 && !ifDone; c++) begin
            @(negedge clk);
            if (mem_en) begin
                if (grants == 0) firstAddr = mem_addr;
                else if (grants == 1) begin secondAddr = mem_addr; ifAfterD = dDone; end
                grants++;
            end
            if (!if_valid && !stall_if) stallBad++;
            if (d_valid) dDone = 1'b1;
            if (if_valid) ifDone = 1'b1;
            tick();
            if (dDone) d_req = 1'b0;
            if (ifDone) if_req = 1'b0;
        end
        checkOutput("contention first grant", firstAddr, 16'h0040);
        checkOutput("contention second grant", secondAddr, 16'h0100);
        checkFlag("contention fetch after d_valid", ifAfterD, 1'b1);
        checkFlag("contention fetch done", ifDone, 1'b1);
        checkOutput("contention stall_if gaps", 16'(stallBad), 16'h0000);

        // Store
        $display("[TB] store");
        memLatency = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0022; d_wdata = 16'h5A5A;
        enCount = 0; dDone = 0;
        for (int c = 0; c < 20 && !dDone; c++) begin
            @(negedge clk);
            if (mem_en) begin
                enCount++;
                checkFlag("store mem_we", mem_we, 1'b1);
                checkOutput("store mem_addr", mem_addr, 16'h0022);
                checkOutput("store mem_wdata", mem_wdata, 16'h5A5A);
            end
            if (d_valid) dDone = 1'b1;
            tick();
            if (dDone) begin d_req = 1'b0; d_we = 1'b0; end
        end
        checkOutput("store strobe count", 16'(enCount), 16'h0001);
        checkFlag("store d_valid", dDone, 1'b1);

        // Halt blocks fetch but not data
        $display("[TB] halt");
        memLatency = 1;
        hlt = 1'b1; if_req = 1'b1; if_addr = 16'h0200;
        fetchGrants = 0; dGrants = 0; dDone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_en) begin
                if (mem_addr == 16'h0200) fetchGrants++;
                else dGrants++;
            end
            if (d_valid) dDone = 1'b1;
            tick();
            if (c == 5) begin d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300; end
            if (dDone) d_req = 1'b0;
        end
        checkOutput("halt fetch grants", 16'(fetchGrants), 16'h0000);
        checkOutput("halt data grants", 16'(dGrants), 16'h0001);
        hlt = 1'b0;
        resumed = 0; ifDone = 0;
        for (int c = 0; c < 10 && !ifDone; c++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 16'h0200) resumed = 1'b1;
            if (if_valid) ifDone = 1'b1;
            tick();
            if (ifDone) if_req = 1'b0;
        end
        checkFlag("halt fetch resumed", resumed, 1'b1);
        checkFlag("halt fetch done", ifDone, 1'b1);

        // Reset during ISSUE, then during WAIT; stray mem_rdy afterwards
        for (int k = 0; k < 2; k++) begin
            $display("[TB] reset mid-access %0d", k);
            memSilent = 1'b1;
            d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
            for (int c = 0; c < 10 && !mem_en; c++) tick();
            checkFlag("reset test reached issue", mem_en, 1'b1);
            if (k == 1) tick();
            rst = 1'b1;
            #1;
            checkFlag("async reset mem_en", mem_en, 1'b0);
            checkFlag("async reset d_valid", d_valid, 1'b0);
            d_req = 1'b0;
            tick();
            tick();
            rst = 1'b0;
            memSilent = 1'b0;
            mem_rdy = 1'b1;
            @(negedge clk);
            checkFlag("stray rdy if_valid", if_valid, 1'b0);
            checkFlag("stray rdy d_valid", d_valid, 1'b0);
            tick();
        end

        // Randomized traffic
        $display("[TB] random");
        memLatency = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            applyStimulus();
        end
        if_req = 1'b0; d_req = 1'b0; hlt = 1'b0;
        repeat (10) tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abort on the 15th WAIT cycle
        $display("[TB] timeout");
        memSilent = 1'b1;
        if_req = 1'b1; if_addr = 16'h0700;
        seenCycle = -1;
        for (int c = 0; c < 25 && seenCycle < 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                seenCycle = c;
                checkFlag("timeout mem_err", mem_err, 1'b1);
                checkOutput("timeout if_rdata", if_rdata, 16'h0000);
            end
            tick();
        end
        checkOutput("timeout cycle", 16'(seenCycle), 16'd16);
        if_req = 1'b0;
        memSilent = 1'b0;
        memLatency = 1;
        @(negedge clk);
        checkFlag("timeout mem_err one cycle", mem_err, 1'b0);
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0710;
        dDone = 0;
        for (int c = 0; c < 10 && !dDone; c++) begin
            @(negedge clk);
            if (d_valid) dDone = 1'b1;
            tick();
            if (dDone) d_req = 1'b0;
        end
        checkFlag("timeout next request served", dDone, 1'b1);
        repeat (3) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
